// File: rtl/decode_stage_pipelined_if.sv
// -----------------------------------------------------------------------------
// decode_stage_pipelined_if
// Purpose : bundles the IF-side instruction handshake, the write-back port and
//           the ID/EX output register of the decode stage into one interface.
// Params  : DATA_W - datapath width, AW - register index width.
// Signals : if_valid/if_instr/if_pc/id_ready   - fetch -> decode handshake
//           wb_we/wb_addr/wb_data               - register-file write-back
//           ex_ready/ex_valid/ex_*              - decode -> execute handshake
// Modports: slave  - the decode stage itself
//           master - the environment (fetch, write-back and execute)
// -----------------------------------------------------------------------------
interface decode_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) ();
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [DATA_W-1:0] if_pc;
  logic              id_ready;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [5:0]        ex_opcode;
  logic [5:0]        ex_funct;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [AW-1:0]     ex_dest;
  logic              ex_mem_read;

  modport slave (
    input  if_valid, if_instr, if_pc, wb_we, wb_addr, wb_data, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_opcode, ex_funct, ex_rs_data,
           ex_rt_data, ex_imm, ex_dest, ex_mem_read
  );

  modport master (
    output if_valid, if_instr, if_pc, wb_we, wb_addr, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_opcode, ex_funct, ex_rs_data,
           ex_rt_data, ex_imm, ex_dest, ex_mem_read
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// -----------------------------------------------------------------------------
// decode_stage_pipelined
// Purpose : MIPS instruction-decode stage. Holds the register file, decodes
//           the instruction fields and immediate, detects load-use hazards
//           against the instruction sitting in ID/EX, and registers the decoded
//           instruction into ID/EX under a valid/ready handshake.
// Params  : DATA_W    - register / datapath width (>= 16)
//           NREGS     - architectural register count (power of 2, <= 32)
//           WB_BYPASS - 1: same-cycle write data is forwarded to reads
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - decode_stage_pipelined_if.slave (IF, WB and EX sides)
// -----------------------------------------------------------------------------
module decode_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter int WB_BYPASS = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  decode_stage_pipelined_if.slave bus
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_pc;
  logic [5:0]        r_ex_opcode;
  logic [5:0]        r_ex_funct;
  logic [DATA_W-1:0] r_ex_rs_data;
  logic [DATA_W-1:0] r_ex_rt_data;
  logic [DATA_W-1:0] r_ex_imm;
  logic [AW-1:0]     r_ex_dest;
  logic              r_ex_mem_read;

  logic [5:0]        w_opcode;
  logic [AW-1:0]     w_rs;
  logic [AW-1:0]     w_rt;
  logic [AW-1:0]     w_rd;
  logic              w_reads_rs;
  logic              w_reads_rt;
  logic [AW-1:0]     w_dest;
  logic              w_mem_read;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic              w_hazard;
  logic              w_advance;
  logic              w_accept;
  logic              w_unused_instr;

  // Register 0 reads as zero; a same-cycle write can be forwarded to the read.
  function automatic logic [DATA_W-1:0] rf_read(
    input logic [AW-1:0]     idx,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [AW-1:0]     waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    if (idx == {AW{1'b0}}) begin
      v = {DATA_W{1'b0}};
    end else if ((WB_BYPASS == 1) && we && (waddr == idx)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  assign w_opcode = bus.if_instr[31:26];
  // Indices are truncated to the register-file size.
  assign w_rs     = bus.if_instr[21 +: AW];
  assign w_rt     = bus.if_instr[16 +: AW];
  assign w_rd     = bus.if_instr[11 +: AW];
  // Shamt and high index bits are not used by this stage.
  assign w_unused_instr = ^bus.if_instr;

  // Operand usage, destination and load flag per opcode class.
  always_comb begin
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    w_dest     = {AW{1'b0}};
    w_mem_read = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
        w_dest     = w_rd;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        w_reads_rs = 1'b1;
        w_dest     = w_rt;
      end
      OP_LW: begin
        w_reads_rs = 1'b1;
        w_dest     = w_rt;
        w_mem_read = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
      end
      OP_J: begin
      end
      OP_JAL: begin
        w_dest = AW'(5'd31);
      end
      default: begin
      end
    endcase
  end

  // Immediate extension: zero for logical ops, upper-half for lui, else sign.
  always_comb begin
    w_imm = {DATA_W{1'b0}};
    case (w_opcode)
      OP_ANDI, OP_ORI: w_imm = DATA_W'(bus.if_instr[15:0]);
      OP_LUI:          w_imm = DATA_W'({bus.if_instr[15:0], 16'h0000});
      default:         w_imm = DATA_W'($signed(bus.if_instr[15:0]));
    endcase
  end

  assign w_rs_data = rf_read(w_rs, r_regs[w_rs], bus.wb_we, bus.wb_addr, bus.wb_data);
  assign w_rt_data = rf_read(w_rt, r_regs[w_rt], bus.wb_we, bus.wb_addr, bus.wb_data);

  // A load in ID/EX whose result is needed now forces a single bubble.
  assign w_hazard  = r_ex_valid & r_ex_mem_read & (r_ex_dest != {AW{1'b0}}) &
                     bus.if_valid &
                     ((w_reads_rs & (w_rs == r_ex_dest)) |
                      (w_reads_rt & (w_rt == r_ex_dest)));
  assign w_advance = ~r_ex_valid | bus.ex_ready;
  assign w_accept  = bus.if_valid & ~w_hazard;

  assign bus.id_ready = w_advance & ~w_hazard;

  // Register file; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.wb_we && (bus.wb_addr != {AW{1'b0}})) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ID/EX register: load on accept, bubble when advancing without one, hold
  // under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= {DATA_W{1'b0}};
      r_ex_opcode   <= 6'h00;
      r_ex_funct    <= 6'h00;
      r_ex_rs_data  <= {DATA_W{1'b0}};
      r_ex_rt_data  <= {DATA_W{1'b0}};
      r_ex_imm      <= {DATA_W{1'b0}};
      r_ex_dest     <= {AW{1'b0}};
      r_ex_mem_read <= 1'b0;
    end else if (w_advance) begin
      if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_pc       <= bus.if_pc;
        r_ex_opcode   <= w_opcode;
        r_ex_funct    <= bus.if_instr[5:0];
        r_ex_rs_data  <= w_rs_data;
        r_ex_rt_data  <= w_rt_data;
        r_ex_imm      <= w_imm;
        r_ex_dest     <= w_dest;
        r_ex_mem_read <= w_mem_read;
      end else begin
        // The load flag must drop with valid so a bubble never looks like a load.
        r_ex_valid    <= 1'b0;
        r_ex_mem_read <= 1'b0;
      end
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_opcode   = r_ex_opcode;
  assign bus.ex_funct    = r_ex_funct;
  assign bus.ex_rs_data  = r_ex_rs_data;
  assign bus.ex_rt_data  = r_ex_rt_data;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.ex_dest     = r_ex_dest;
  assign bus.ex_mem_read = r_ex_mem_read;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_pipelined
// Drives three decode-stage builds from one directed stimulus stream:
//   c0: DATA_W=32 NREGS=32 WB_BYPASS=1
//   c1: DATA_W=32 NREGS=32 WB_BYPASS=0
//   c2: DATA_W=16 NREGS=16 WB_BYPASS=1
// A behavioural model of each build is checked on every falling edge, and a
// set of hand-computed literal values is checked after selected transfers.
// -----------------------------------------------------------------------------
module tb_decode_stage_pipelined;
  localparam int NC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;

  int n_checks = 0;
  int n_err    = 0;

  int cfg_dw [NC] = '{32, 32, 16};
  int cfg_nr [NC] = '{32, 32, 16};
  int cfg_bp [NC] = '{1, 0, 1};

  always #5 clk = ~clk;

  decode_stage_pipelined_if #(.DATA_W(32), .AW(5)) b0 ();
  decode_stage_pipelined_if #(.DATA_W(32), .AW(5)) b1 ();
  decode_stage_pipelined_if #(.DATA_W(16), .AW(4)) b2 ();

  assign b0.if_valid = if_valid;       assign b1.if_valid = if_valid;       assign b2.if_valid = if_valid;
  assign b0.if_instr = if_instr;       assign b1.if_instr = if_instr;       assign b2.if_instr = if_instr;
  assign b0.if_pc    = if_pc;          assign b1.if_pc    = if_pc;          assign b2.if_pc    = if_pc[15:0];
  assign b0.wb_we    = wb_we;          assign b1.wb_we    = wb_we;          assign b2.wb_we    = wb_we;
  assign b0.wb_addr  = wb_addr;        assign b1.wb_addr  = wb_addr;        assign b2.wb_addr  = wb_addr[3:0];
  assign b0.wb_data  = wb_data;        assign b1.wb_data  = wb_data;        assign b2.wb_data  = wb_data[15:0];
  assign b0.ex_ready = ex_ready;       assign b1.ex_ready = ex_ready;       assign b2.ex_ready = ex_ready;

  decode_stage_pipelined #(.DATA_W(32), .NREGS(32), .WB_BYPASS(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  decode_stage_pipelined #(.DATA_W(32), .NREGS(32), .WB_BYPASS(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  decode_stage_pipelined #(.DATA_W(16), .NREGS(16), .WB_BYPASS(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  // DUT outputs widened into per-build arrays.
  wire        d_rdy [NC];
  wire        d_ev  [NC];
  wire        d_mr  [NC];
  wire [31:0] d_pc  [NC];
  wire [31:0] d_rs  [NC];
  wire [31:0] d_rt  [NC];
  wire [31:0] d_imm [NC];
  wire [5:0]  d_op  [NC];
  wire [5:0]  d_fn  [NC];
  wire [4:0]  d_dest[NC];

  assign d_rdy[0] = b0.id_ready;   assign d_rdy[1] = b1.id_ready;   assign d_rdy[2] = b2.id_ready;
  assign d_ev[0]  = b0.ex_valid;   assign d_ev[1]  = b1.ex_valid;   assign d_ev[2]  = b2.ex_valid;
  assign d_mr[0]  = b0.ex_mem_read; assign d_mr[1] = b1.ex_mem_read; assign d_mr[2] = b2.ex_mem_read;
  assign d_pc[0]  = b0.ex_pc;      assign d_pc[1]  = b1.ex_pc;      assign d_pc[2]  = {16'h0000, b2.ex_pc};
  assign d_rs[0]  = b0.ex_rs_data; assign d_rs[1]  = b1.ex_rs_data; assign d_rs[2]  = {16'h0000, b2.ex_rs_data};
  assign d_rt[0]  = b0.ex_rt_data; assign d_rt[1]  = b1.ex_rt_data; assign d_rt[2]  = {16'h0000, b2.ex_rt_data};
  assign d_imm[0] = b0.ex_imm;     assign d_imm[1] = b1.ex_imm;     assign d_imm[2] = {16'h0000, b2.ex_imm};
  assign d_op[0]  = b0.ex_opcode;  assign d_op[1]  = b1.ex_opcode;  assign d_op[2]  = b2.ex_opcode;
  assign d_fn[0]  = b0.ex_funct;   assign d_fn[1]  = b1.ex_funct;   assign d_fn[2]  = b2.ex_funct;
  assign d_dest[0] = b0.ex_dest;   assign d_dest[1] = b1.ex_dest;   assign d_dest[2] = {1'b0, b2.ex_dest};

  // Behavioural model state, one entry per build.
  logic [31:0] m_regs [NC][32];
  logic        m_ev  [NC];
  logic        m_mr  [NC];
  logic [31:0] m_pc  [NC];
  logic [31:0] m_rs  [NC];
  logic [31:0] m_rt  [NC];
  logic [31:0] m_imm [NC];
  logic [5:0]  m_op  [NC];
  logic [5:0]  m_fn  [NC];
  logic [4:0]  m_dest[NC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input int c, input logic [4:0] idx,
                                           input logic [4:0] wa, input logic [31:0] dm);
    if (idx == 5'd0) return 32'd0;
    if (cfg_bp[c] == 1 && wb_we && wa == idx) return wb_data & dm;
    return m_regs[c][idx];
  endfunction

  logic [31:0] dm, vrs, vrt, imm;
  logic [4:0]  im, rs, rt, rd, wa, dst;
  logic [5:0]  op;
  logic        rrs, rrt, mrd, haz, adv;

  // Compare DUT against the model, then advance the model by one clock.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_ev[c] = 1'b0; m_mr[c] = 1'b0; m_pc[c] = 32'd0; m_rs[c] = 32'd0;
        m_rt[c] = 32'd0; m_imm[c] = 32'd0; m_op[c] = 6'd0; m_fn[c] = 6'd0; m_dest[c] = 5'd0;
        for (int r = 0; r < 32; r++) m_regs[c][r] = 32'd0;
      end
    end
    for (int c = 0; c < NC; c++) begin
      dm  = (cfg_dw[c] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_dw[c]) - 32'd1);
      im  = 5'(cfg_nr[c] - 1);
      op  = if_instr[31:26];
      rs  = if_instr[25:21] & im;
      rt  = if_instr[20:16] & im;
      rd  = if_instr[15:11] & im;
      rrs = op inside {6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
      rrt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
      mrd = (op == 6'h23);
      if (op == 6'h00) dst = rd;
      else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23}) dst = rt;
      else if (op == 6'h03) dst = 5'd31 & im;
      else dst = 5'd0;
      if (op inside {6'h0C, 6'h0D}) imm = {16'h0000, if_instr[15:0]};
      else if (op == 6'h0F) imm = {if_instr[15:0], 16'h0000};
      else imm = {{16{if_instr[15]}}, if_instr[15:0]};
      imm = imm & dm;
      haz = m_ev[c] && m_mr[c] && (m_dest[c] != 5'd0) && if_valid &&
            ((rrs && rs == m_dest[c]) || (rrt && rt == m_dest[c]));
      adv = !m_ev[c] || ex_ready;

      chk($sformatf("c%0d id_ready", c), 32'(d_rdy[c]), 32'(adv && !haz));
      chk($sformatf("c%0d ex_valid", c), 32'(d_ev[c]), 32'(m_ev[c]));
      chk($sformatf("c%0d ex_mem_read", c), 32'(d_mr[c]), 32'(m_mr[c]));
      if (m_ev[c] || !rst_n) begin
        chk($sformatf("c%0d ex_pc", c), d_pc[c], m_pc[c]);
        chk($sformatf("c%0d ex_opcode", c), 32'(d_op[c]), 32'(m_op[c]));
        chk($sformatf("c%0d ex_funct", c), 32'(d_fn[c]), 32'(m_fn[c]));
        chk($sformatf("c%0d ex_rs_data", c), d_rs[c], m_rs[c]);
        chk($sformatf("c%0d ex_rt_data", c), d_rt[c], m_rt[c]);
        chk($sformatf("c%0d ex_imm", c), d_imm[c], m_imm[c]);
        chk($sformatf("c%0d ex_dest", c), 32'(d_dest[c]), 32'(m_dest[c]));
      end

      if (rst_n) begin
        wa  = wb_addr & im;
        vrs = rd_model(c, rs, wa, dm);
        vrt = rd_model(c, rt, wa, dm);
        if (adv) begin
          if (if_valid && !haz) begin
            m_ev[c] = 1'b1; m_mr[c] = mrd; m_pc[c] = if_pc & dm; m_op[c] = op;
            m_fn[c] = if_instr[5:0]; m_rs[c] = vrs; m_rt[c] = vrt; m_imm[c] = imm;
            m_dest[c] = dst;
          end else begin
            m_ev[c] = 1'b0;
            m_mr[c] = 1'b0;
          end
        end
        if (wb_we && wa != 5'd0) m_regs[c][wa] = wb_data & dm;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  // Directed stimulus with hand-computed literal checks.
  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 32'(d_ev[0]), 32'd0);
    chk("reset id_ready", 32'(d_rdy[0]), 32'd1);
    rst_n = 1'b1;
    step();

    // Write $5 then add $3,$5,$0
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    step();
    wb_we = 1'b0; drive(32'h00A0_1820, 32'h0000_0100);
    step();
    if_valid = 1'b0;
    #1;
    chk("add ex_valid", 32'(d_ev[0]), 32'd1);
    chk("add rs_data", d_rs[0], 32'h0000_1234);
    chk("add rt_data", d_rt[0], 32'h0000_0000);
    chk("add dest", 32'(d_dest[0]), 32'd3);
    chk("narrow add rs_data", d_rs[2], 32'h0000_1234);
    chk("narrow add dest", 32'(d_dest[2]), 32'd3);
    step();

    // addi $9,$8,-1 with simultaneous write of $8
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEAD_BEEF; drive(32'h2109_FFFF, 32'h0000_0104);
    step();
    wb_we = 1'b0; if_valid = 1'b0;
    #1;
    chk("bypass rs_data", d_rs[0], 32'hDEAD_BEEF);
    chk("bypass imm", d_imm[0], 32'hFFFF_FFFF);
    chk("nobypass rs_data", d_rs[1], 32'h0000_0000);
    chk("narrow bypass rs_data", d_rs[2], 32'h0000_BEEF);

    // ori / lui immediates
    drive(32'h3402_8000, 32'h0000_0108);
    step();
    #1;
    chk("ori imm", d_imm[0], 32'h0000_8000);
    drive(32'h3C02_1234, 32'h0000_010C);
    step();
    #1;
    chk("lui imm", d_imm[0], 32'h1234_0000);
    chk("narrow lui imm", d_imm[2], 32'h0000_0000);
    chk("lui dest", 32'(d_dest[0]), 32'd2);

    // Load-use: lw $4,0($1) then add $5,$4,$4
    drive(32'h8C24_0000, 32'h0000_0110);
    step();
    drive(32'h0084_2820, 32'h0000_0114);
    #1;
    chk("load-use id_ready", 32'(d_rdy[0]), 32'd0);
    step();
    chk("bubble ex_valid", 32'(d_ev[0]), 32'd0);
    chk("bubble mem_read", 32'(d_mr[0]), 32'd0);
    chk("after bubble id_ready", 32'(d_rdy[0]), 32'd1);
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0055;
    step();
    wb_we = 1'b0; if_valid = 1'b0;
    #1;
    chk("stalled add valid", 32'(d_ev[0]), 32'd1);
    chk("stalled add dest", 32'(d_dest[0]), 32'd5);
    chk("stalled add rs bypass", d_rs[0], 32'h0000_0055);
    chk("stalled add rs nobypass", d_rs[1], 32'h0000_0000);

    // lw $4 followed by independent add $5,$6,$7
    drive(32'h8C24_0000, 32'h0000_0118);
    step();
    drive(32'h00C7_2820, 32'h0000_011C);
    #1;
    chk("no-stall id_ready", 32'(d_rdy[0]), 32'd1);
    step();
    if_valid = 1'b0;
    #1;
    chk("no-stall pc", d_pc[0], 32'h0000_011C);

    // Back-pressure for three cycles
    drive(32'h3402_0077, 32'h0000_0120);
    step();
    ex_ready = 1'b0; drive(32'h3C02_ABCD, 32'h0000_0124);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("backpressure id_ready", 32'(d_rdy[0]), 32'd0);
      step();
    end
    #1;
    chk("backpressure hold imm", d_imm[0], 32'h0000_0077);
    chk("backpressure hold valid", 32'(d_ev[0]), 32'd1);
    ex_ready = 1'b1;
    #1;
    chk("release id_ready", 32'(d_rdy[0]), 32'd1);
    step();
    if_valid = 1'b0;
    #1;
    chk("release imm", d_imm[0], 32'hABCD_0000);

    // jal, sw and an unlisted opcode
    drive(32'h0C00_0000, 32'h0000_0128);
    step();
    drive(32'hAC24_0000, 32'h0000_012C);
    #1;
    chk("jal dest", 32'(d_dest[0]), 32'd31);
    chk("narrow jal dest", 32'(d_dest[2]), 32'd15);
    step();
    drive(32'hFC00_0000, 32'h0000_0130);
    #1;
    chk("sw dest", 32'(d_dest[0]), 32'd0);
    step();
    if_valid = 1'b0;
    #1;
    chk("unlisted opcode", 32'(d_op[0]), 32'h0000_003F);

    // Writes to $0 are ignored
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF; drive(32'h0000_1820, 32'h0000_0134);
    step();
    wb_we = 1'b0;
    step();
    if_valid = 1'b0;
    #1;
    chk("reg0 rs_data", d_rs[0], 32'h0000_0000);
    chk("reg0 rt_data", d_rt[0], 32'h0000_0000);

    // Reset in the middle of a load-use stall
    drive(32'h8C24_0000, 32'h0000_0138);
    step();
    drive(32'h0084_2820, 32'h0000_013C);
    #1;
    chk("pre-reset stall", 32'(d_rdy[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid-stall reset valid", 32'(d_ev[0]), 32'd0);
    step();
    rst_n = 1'b1; if_valid = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
